// File: rtl/dpmem_pkg.sv
// Shared types and constants for the pipelined dual-port memory.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dpmem_pkg;

   // Clear-sweep controller states
   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   // Granularity of the write byte enables
   localparam int BYTE_W = 8;

endpackage

// File: rtl/dpmem_init_seq.sv
// Clear-sweep sequencer: walks every address once after reset so the array starts zeroed.
// Latency: busy stays high for exactly DEPTH cycles after the last reset edge.
// Backpressure: none; the sweep cannot be stalled, the memory simply ignores users while busy.
module dpmem_init_seq
   import dpmem_pkg::*;
#(
   parameter int DEPTH      = 64,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] clr_addr,
   output logic                  clr_en
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   sweep_ptr;

   // Sweep FSM: one address per cycle in INIT, leave to RUN after the top address
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= INIT;
         sweep_ptr <= '0;
         busy      <= 1'b1;
      end else begin
         case (state)
            INIT: begin
               sweep_ptr <= sweep_ptr + 1'b1;
               if (sweep_ptr == LAST_ADDR) begin
                  state <= RUN;
                  busy  <= 1'b0;
               end
            end
            RUN: begin
               busy <= 1'b0;
            end
            default: begin
               state <= INIT;
               busy  <= 1'b1;
            end
         endcase
      end
   end

   // The array must not be touched while reset is held, even though busy is high
   assign clr_addr = sweep_ptr;
   assign clr_en   = busy & ~rst;

endmodule

// File: rtl/pipelined_dualport_mem.sv
// Simple dual-port RAM with byte-enabled writes, a self-clearing sweep after reset, and a pipelined read port.
// Latency: rd_en to rd_valid is READ_LATENCY (1 or 2) cycles; one read accepted per cycle.
// Backpressure: none; accesses during the clear sweep (init_busy=1) are dropped. Macro DPMEM_BYPASS_EN makes same-address read-during-write return new data.
module pipelined_dualport_mem
   import dpmem_pkg::*;
#(
   parameter  int DATA_WIDTH   = 32,
   parameter  int DEPTH        = 64,
   parameter  int READ_LATENCY = 1,
   localparam int ADDR_WIDTH   = $clog2(DEPTH),
   localparam int NBYTES       = DATA_WIDTH / BYTE_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [NBYTES-1:0]     wr_be,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  init_busy
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic                  busy;
   logic [ADDR_WIDTH-1:0] clr_addr;
   logic                  clr_en;

   logic                  wr_accept;
   logic                  rd_accept;

   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [NBYTES-1:0]     mem_be;

   logic [DATA_WIDTH-1:0] rd_word;

   logic [DATA_WIDTH-1:0] pipe_dat [READ_LATENCY];
   logic [READ_LATENCY-1:0] pipe_vld;

   dpmem_init_seq #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_init_seq (
      .clk      (clk),
      .rst      (rst),
      .busy     (busy),
      .clr_addr (clr_addr),
      .clr_en   (clr_en)
   );

   assign init_busy = busy;
   assign wr_accept = wr_en & ~busy & ~rst;
   assign rd_accept = rd_en & ~busy & ~rst;

   // Single write port shared between the clear sweep and user writes
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = wr_addr;
      mem_wdata = wr_data;
      mem_be    = wr_be;
      if (clr_en) begin
         mem_we    = 1'b1;
         mem_waddr = clr_addr;
         mem_wdata = '0;
         mem_be    = '1;
      end else if (wr_accept) begin
         mem_we    = 1'b1;
      end
   end

   // Byte-lane write into the storage array (no reset so it maps to block RAM)
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (mem_be[i]) begin
               mem[mem_waddr][i*BYTE_W +: BYTE_W] <= mem_wdata[i*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   // Read word feeding the first pipeline stage, optionally merged with a colliding write
   always_comb begin
      rd_word = mem[rd_addr];
`ifdef DPMEM_BYPASS_EN
      if (wr_accept && (wr_addr == rd_addr)) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (wr_be[i]) begin
               rd_word[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
            end
         end
      end
`endif
   end

   // Read pipeline: data stages only load when a valid read passes, so rd_data holds otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_vld <= '0;
         for (int k = 0; k < READ_LATENCY; k++) begin
            pipe_dat[k] <= '0;
         end
      end else begin
         pipe_vld[0] <= rd_accept;
         if (rd_accept) begin
            pipe_dat[0] <= rd_word;
         end
         for (int k = 1; k < READ_LATENCY; k++) begin
            pipe_vld[k] <= pipe_vld[k-1];
            if (pipe_vld[k-1]) begin
               pipe_dat[k] <= pipe_dat[k-1];
            end
         end
      end
   end

   // A read landing in the same cycle reset is asserted is discarded, not reported
   assign rd_data  = pipe_dat[READ_LATENCY-1];
   assign rd_valid = pipe_vld[READ_LATENCY-1] & ~rst;

endmodule

// File: tb/tb_pipelined_dualport_mem.sv
// Bench for pipelined_dualport_mem: latency-1 and latency-2 instances share one stimulus stream.
// Latency: n/a.
// Backpressure: n/a.
module tb_pipelined_dualport_mem;

   localparam int DW = 32;
   localparam int D  = 64;
   localparam int AW = 6;
   localparam int HN = 4096;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [3:0]    wr_be;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data1, rd_data2;
   logic          rd_valid1, rd_valid2;
   logic          init_busy1, init_busy2;

   always #5 clk = ~clk;

   pipelined_dualport_mem #(.DATA_WIDTH(DW), .DEPTH(D), .READ_LATENCY(1)) u_lat1 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1), .init_busy(init_busy1)
   );

   pipelined_dualport_mem #(.DATA_WIDTH(DW), .DEPTH(D), .READ_LATENCY(2)) u_lat2 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data2), .rd_valid(rd_valid2), .init_busy(init_busy2)
   );

   int vectors    = 0;
   int miscompares = 0;

   // ---------------- reference model ----------------
   int            cyc = 0;
   bit            started = 0;
   int            init_left = 0;
   logic [DW-1:0] ref_mem [D];
   bit            hv [HN];       // read accepted in that cycle
   logic [DW-1:0] hd [HN];       // data that read must return
   bit            hr [HN];       // reset high in that cycle
   logic [DW-1:0] last1 = '0;
   logic [DW-1:0] last2 = '0;

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                           input logic [3:0] be);
      logic [DW-1:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
      return r;
   endfunction

   // Memory image: zeroed by reset, written by user writes once the sweep time has elapsed
   always @(posedge clk) begin
      if (rst) begin
         started   = 1;
         init_left = D;
         for (int i = 0; i < D; i++) ref_mem[i] = '0;
         last1 = '0;
         last2 = '0;
      end else if (started) begin
         if (init_left > 0) init_left--;
         else if (wr_en) ref_mem[wr_addr] = merge(ref_mem[wr_addr], wr_data, wr_be);
      end
      cyc++;
   end

   // Scoreboard: a read from cycle c is reported at c+L unless reset intervened
   always @(negedge clk) begin : mon
      bit            busy_e, acc, arr;
      logic [DW-1:0] rw;
      if (started) begin
         busy_e = (init_left > 0);
         hr[cyc % HN] = rst;
         acc = rd_en && !rst && !busy_e;
         rw = ref_mem[rd_addr];
`ifdef DPMEM_BYPASS_EN
         if (wr_en && !rst && !busy_e && wr_addr == rd_addr) rw = merge(rw, wr_data, wr_be);
`endif
         hv[cyc % HN] = acc;
         hd[cyc % HN] = rw;

         arr = (cyc >= 1) && hv[(cyc-1) % HN];
         if (arr) last1 = hd[(cyc-1) % HN];
         vectors += 3;
         if (init_busy1 !== busy_e) begin miscompares++; $display("FAIL sb_busy_l1 cyc=%0d got %b expected %b", cyc, init_busy1, busy_e); end
         if (rd_valid1 !== (arr && !rst)) begin miscompares++; $display("FAIL sb_valid_l1 cyc=%0d got %b expected %b", cyc, rd_valid1, arr && !rst); end
         if (rd_data1 !== last1) begin miscompares++; $display("FAIL sb_data_l1 cyc=%0d got %h expected %h", cyc, rd_data1, last1); end

         arr = (cyc >= 2) && hv[(cyc-2) % HN] && !hr[(cyc-1) % HN];
         if (arr) last2 = hd[(cyc-2) % HN];
         vectors += 3;
         if (init_busy2 !== busy_e) begin miscompares++; $display("FAIL sb_busy_l2 cyc=%0d got %b expected %b", cyc, init_busy2, busy_e); end
         if (rd_valid2 !== (arr && !rst)) begin miscompares++; $display("FAIL sb_valid_l2 cyc=%0d got %b expected %b", cyc, rd_valid2, arr && !rst); end
         if (rd_data2 !== last2) begin miscompares++; $display("FAIL sb_data_l2 cyc=%0d got %h expected %h", cyc, rd_data2, last2); end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 0; wr_en = 0; rd_en = 0;
      wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int cnt;
      idle();
      rst = 1;
      repeat (3) step();
      rst = 0;
      cnt = 0;
      // Random traffic during the sweep must be ignored
      for (int i = 0; i < 200; i++) begin
         wr_en = 1'($urandom_range(0, 1)); wr_addr = AW'($urandom_range(0, D-1));
         wr_data = $urandom; wr_be = 4'hF;
         rd_en = 1'($urandom_range(0, 1)); rd_addr = AW'($urandom_range(0, D-1));
         @(negedge clk);
         if (!init_busy1) break;
         vectors++;
         if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0) begin
            miscompares++; $display("FAIL reset_no_valid got %b/%b expected 0/0", rd_valid1, rd_valid2);
         end
         cnt++;
         step();
      end
      idle();
      vectors++;
      if (cnt !== 64) begin miscompares++; $display("FAIL reset_busy_cycles got %0d expected 64", cnt); end
      vectors++;
      if (init_busy2 !== 1'b0) begin miscompares++; $display("FAIL reset_busy_l2 got %b expected 0", init_busy2); end
      step();
      rd_en = 1; rd_addr = 6'd17;
      step();
      rd_en = 1; rd_addr = 6'd63;
      @(negedge clk);
      vectors++;
      if (rd_valid1 !== 1'b1 || rd_data1 !== 32'h0) begin
         miscompares++; $display("FAIL reset_read_zero got %b/%h expected 1/00000000", rd_valid1, rd_data1);
      end
      step();
      idle();
      @(negedge clk);
      vectors++;
      if (rd_valid2 !== 1'b1 || rd_data2 !== 32'h0) begin
         miscompares++; $display("FAIL reset_read_zero_l2 got %b/%h expected 1/00000000", rd_valid2, rd_data2);
      end
      repeat (3) step();
   endtask

   task automatic test_write_read();
      wr_en = 1; wr_addr = 6'd5; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
      step();
      idle();
      rd_en = 1; rd_addr = 6'd5;
      step();
      idle();
      @(negedge clk);
      vectors++;
      if (rd_valid1 !== 1'b1 || rd_data1 !== 32'hDEADBEEF) begin
         miscompares++; $display("FAIL wr_rd_l1 got %b/%h expected 1/deadbeef", rd_valid1, rd_data1);
      end
      vectors++;
      if (rd_valid2 !== 1'b0) begin miscompares++; $display("FAIL wr_rd_l2_early got %b expected 0", rd_valid2); end
      step();
      @(negedge clk);
      vectors++;
      if (rd_valid2 !== 1'b1 || rd_data2 !== 32'hDEADBEEF) begin
         miscompares++; $display("FAIL wr_rd_l2 got %b/%h expected 1/deadbeef", rd_valid2, rd_data2);
      end
      vectors++;
      if (rd_valid1 !== 1'b0 || rd_data1 !== 32'hDEADBEEF) begin
         miscompares++; $display("FAIL wr_rd_l1_hold got %b/%h expected 0/deadbeef", rd_valid1, rd_data1);
      end
      step();
   endtask

   task automatic test_partial_write();
      wr_en = 1; wr_addr = 6'd5; wr_data = 32'h11223344; wr_be = 4'b0101;
      step();
      idle();
      rd_en = 1; rd_addr = 6'd5;
      step();
      idle();
      step();
      @(negedge clk);
      vectors++;
      if (rd_valid2 !== 1'b1 || rd_data2 !== 32'hDE22BE44) begin
         miscompares++; $display("FAIL partial_be got %b/%h expected 1/de22be44", rd_valid2, rd_data2);
      end
      // All-zero enables must leave the word untouched
      wr_en = 1; wr_addr = 6'd5; wr_data = 32'hFFFFFFFF; wr_be = 4'b0000;
      step();
      idle();
      rd_en = 1; rd_addr = 6'd5;
      step();
      idle();
      @(negedge clk);
      vectors++;
      if (rd_data1 !== 32'hDE22BE44) begin
         miscompares++; $display("FAIL zero_be got %h expected de22be44", rd_data1);
      end
      step();
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] vals [8];
      for (int i = 0; i < 8; i++) begin
         vals[i] = $urandom;
         wr_en = 1; wr_addr = AW'(i); wr_data = vals[i]; wr_be = 4'hF;
         step();
      end
      idle();
      for (int t = 0; t < 12; t++) begin
         rd_en = (t < 8); rd_addr = AW'(t);
         @(negedge clk);
         vectors += 2;
         if (rd_valid1 !== (t >= 1 && t <= 8)) begin
            miscompares++; $display("FAIL b2b_valid_l1 t=%0d got %b expected %b", t, rd_valid1, (t >= 1 && t <= 8));
         end
         if (rd_valid2 !== (t >= 2 && t <= 9)) begin
            miscompares++; $display("FAIL b2b_valid_l2 t=%0d got %b expected %b", t, rd_valid2, (t >= 2 && t <= 9));
         end
         if (t >= 1 && t <= 8) begin
            vectors++;
            if (rd_data1 !== vals[t-1]) begin miscompares++; $display("FAIL b2b_data_l1 t=%0d got %h expected %h", t, rd_data1, vals[t-1]); end
         end
         if (t >= 2 && t <= 9) begin
            vectors++;
            if (rd_data2 !== vals[t-2]) begin miscompares++; $display("FAIL b2b_data_l2 t=%0d got %h expected %h", t, rd_data2, vals[t-2]); end
         end
         step();
      end
      idle();
   endtask

   task automatic test_read_during_write();
      logic [DW-1:0] exp_rdw;
`ifdef DPMEM_BYPASS_EN
      exp_rdw = 32'h55555555;
`else
      exp_rdw = 32'hAAAAAAAA;
`endif
      wr_en = 1; wr_addr = 6'd9; wr_data = 32'hAAAAAAAA; wr_be = 4'hF;
      step();
      wr_en = 1; wr_addr = 6'd9; wr_data = 32'h55555555; wr_be = 4'hF;
      rd_en = 1; rd_addr = 6'd9;
      step();
      idle();
      rd_en = 1; rd_addr = 6'd9;
      @(negedge clk);
      vectors++;
      if (rd_valid1 !== 1'b1 || rd_data1 !== exp_rdw) begin
         miscompares++; $display("FAIL rdw_l1 got %b/%h expected 1/%h", rd_valid1, rd_data1, exp_rdw);
      end
      step();
      idle();
      @(negedge clk);
      vectors++;
      if (rd_valid2 !== 1'b1 || rd_data2 !== exp_rdw) begin
         miscompares++; $display("FAIL rdw_l2 got %b/%h expected 1/%h", rd_valid2, rd_data2, exp_rdw);
      end
      vectors++;
      if (rd_data1 !== 32'h55555555) begin
         miscompares++; $display("FAIL rdw_after got %h expected 55555555", rd_data1);
      end
      step();
   endtask

   task automatic test_reset_inflight();
      int cnt;
      rd_en = 1; rd_addr = 6'd5;
      step();
      idle();
      rst = 1;
      @(negedge clk);
      vectors++;
      if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0) begin
         miscompares++; $display("FAIL inflight_rst_cycle got %b/%b expected 0/0", rd_valid1, rd_valid2);
      end
      step();
      rst = 0;
      cnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!init_busy2) break;
         vectors++;
         if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0) begin
            miscompares++; $display("FAIL inflight_discard got %b/%b expected 0/0", rd_valid1, rd_valid2);
         end
         cnt++;
         step();
      end
      vectors++;
      if (cnt !== 64) begin miscompares++; $display("FAIL inflight_busy_cycles got %0d expected 64", cnt); end
      step();
      rd_en = 1; rd_addr = 6'd5;
      step();
      rd_en = 1; rd_addr = 6'd9;
      step();
      idle();
      @(negedge clk);
      vectors++;
      if (rd_valid2 !== 1'b1 || rd_data2 !== 32'h0) begin
         miscompares++; $display("FAIL inflight_cleared got %b/%h expected 1/00000000", rd_valid2, rd_data2);
      end
      step();
      @(negedge clk);
      vectors++;
      if (rd_valid2 !== 1'b1 || rd_data2 !== 32'h0) begin
         miscompares++; $display("FAIL inflight_cleared9 got %b/%h expected 1/00000000", rd_valid2, rd_data2);
      end
      step();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst     = ($urandom_range(0, 149) == 0);
         wr_en   = 1'($urandom_range(0, 1));
         wr_addr = AW'($urandom_range(0, 15));
         wr_data = $urandom;
         wr_be   = 4'($urandom_range(0, 15));
         rd_en   = 1'($urandom_range(0, 1));
         rd_addr = AW'($urandom_range(0, 15));
         step();
      end
      idle();
      repeat (4) step();
   endtask

   initial begin
      idle();
      rst = 1;
      test_reset();
      test_write_read();
      test_partial_write();
      test_back_to_back();
      test_read_during_write();
      test_reset_inflight();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
